stack_calc_core: RTL
====================

Name: stack_calc_core

Overview:
Parametrised successor to the 4-bit stack calculator CPU. It has a configurable word width, stack depth and input-beat width, and multi-beat operand loading with a valid/ready handshake. It adds saturating depth tracking with sticky overflow/underflow flags, and a SUB binary op. It sits behind the pin-level wrapper, which handles pin mapping, the seven-seg decoders and the output mux, and exposes the stack top, flags and output latch.

Parameters:
WIDTH, 8, data word width; must be a multiple of IN_BITS, minimum 4.
DEPTH, 8, number of stack entries, minimum 2.
IN_BITS, 4, width of the input beat (opcode, sub-op and operand beats).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset: one clock; reset is synchronous and active-low
in_data  in  IN_BITS  opcode, sub-op or operand beat
in_valid  in  1  in_data valid
in_ready  out  1  core accepts a beat this cycle
out_data  out  WIDTH  output latch, written by OUT
top_word  out  WIDTH  stack entry 0; reads 0 if depth<1
second_word  out  WIDTH  stack entry 1; reads 0 if depth<2
depth  out  $clog2(DEPTH+1)  current entry count
carry_flag, error_flag, overflow_flag, underflow_flag  out  1 each  sticky status flags
busy  out  1  high in any state other than FETCH

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=FETCH; depth=0; all entries=0; out_data=0; all flags=0.
  - Beat counter and sub-op cleared; any partial operation is discarded.
- Beat transfer: a beat is accepted on a posedge where in_valid && in_ready. in_ready=1 only in FETCH, LOAD and SUBOP.
- BEATS = WIDTH/IN_BITS.
- FETCH: accept opcode.
  - 1 -> LOAD; 6/7/8 -> SUBOP; all others -> EXEC.
- LOAD: accept BEATS operand beats, little-endian (first beat = bits [IN_BITS-1:0]), then -> EXEC.
- SUBOP: accept one beat; its low 3 bits are latched as the sub-op; -> EXEC.
- EXEC: one cycle, performs the stack update. MULT and IDIV -> EXEC2; everything else -> FETCH.
- EXEC2: pushes the second result word; -> FETCH.
- Opcodes (4-bit):
  - 0 NOOP.
  - 1 PUSH: push the operand.
  - 2 POP.
  - 3 OUT: out_data<=top.
  - 4 SWAP.
  - 5 DUP.
  - 6 PUSF, push by sub-op: 0 top, 1 second, 2 {overflow,underflow,error,carry} zero-extended, 3 depth zero-extended, others push 0.
  - 7 REPL, replace top by sub-op: NOT, NEG, INC, DEC, SHR1, SHL1, ROR1, ROL1. All arithmetic modulo 2^WIDTH.
  - 8 BINA, pop top(a) and second(b), push result by sub-op: 0 ADD a+b (carry<=bit WIDTH), 1 AND, 2 OR, 3 XOR, 4 ADDC a+b+carry (carry updated), 5 MULL, 6 MULH (low/high WIDTH bits of a*b), 7 SUB b-a (carry<=borrow).
  - 9 MULT: 2*WIDTH product of a*b. EXEC replaces both entries with the low word; EXEC2 pushes the high word. Net depth unchanged.
  - A IDIV: EXEC replaces both entries with b/a; EXEC2 pushes b%a. If a=0: error<=1, both results 0.
  - B CLFL: clears all four flags.
  - C-F: NOOP.
- Operand-count rule: required depth is 1 for POP/OUT/DUP/REPL/PUSF sub 0; 2 for SWAP/BINA/MULT/IDIV/PUSF sub 1.
  - If depth is below the requirement: no stack or out_data change, underflow_flag<=1, EXEC2 skipped.
- Full rule: if depth==DEPTH, any op whose net effect is a push (PUSH, DUP, PUSF) drops the push: stack unchanged, overflow_flag<=1.
- Depth saturates at 0 and DEPTH; it never wraps.
- EXEC2 of MULT/IDIV cannot overflow, since EXEC freed a slot.
- Popped and vacated entries are written to 0.
- Flags are sticky and cleared only by CLFL or reset. Simultaneous set and CLFL cannot occur, because CLFL sets nothing.

Decomposition:
- Shared package/constants file: opcode values, REPL/BINA/PUSF sub-op codes, state encoding (FETCH, LOAD, SUBOP, EXEC, EXEC2), stack-mode codes (IDLE/PUSH/POP/SWAP/ROLL/ROLL2/RESET).
- Sub-module stack_array #(WIDTH, DEPTH): shift-style register stack with mode input. It outputs top/second and depth, plus full/empty.
- The ALU stays inline in stack_calc_core.

Test Plan:
- WIDTH=8, DEPTH=4, IN_BITS=4. Reset; PUSH beats 5,A; then PUSH beats 2,1 -> top=0x12, second=0xA5, depth=2; in_ready low for exactly 1 EXEC cycle after each PUSH.
- Push 0xF0, 0x20; BINA sub 0 -> top=0x10, carry=1, depth=1. Push 0x05, BINA sub 7 (0x10-0x05) -> top=0x0B, carry=0.
- Push 0x10, 0x20; MULT -> top=0x02, second=0x00, depth=2. Push 0x07, 0x00; IDIV -> error=1, top=0, second=0. CLFL -> all flags 0.
- Push 5 words into DEPTH=4 -> depth=4, overflow=1, top=4th value. Then 4 POPs plus 1 more POP -> depth=0, underflow=1, top_word=0. PUSF sub 2 pushes 0x0C.
- Hold in_valid low for 3 cycles mid-PUSH after the first beat -> core waits in LOAD; the result is identical to the back-to-back case.
- Drive rst_n=0 after one PUSH beat -> next cycle depth=0, busy=0, in_ready=1; the following opcode decodes normally.

Source files
------------

// File: rtl/stack_calc_core_pkg.sv
// Shared encodings for the stack calculator core: opcodes, sub-ops, FSM states
// and stack-array modes, plus the operand-count helper.
package stack_calc_core_pkg;

  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_POP  = 4'h2;
  localparam logic [3:0] OP_OUT  = 4'h3;
  localparam logic [3:0] OP_SWAP = 4'h4;
  localparam logic [3:0] OP_DUP  = 4'h5;
  localparam logic [3:0] OP_PUSF = 4'h6;
  localparam logic [3:0] OP_REPL = 4'h7;
  localparam logic [3:0] OP_BINA = 4'h8;
  localparam logic [3:0] OP_MULT = 4'h9;
  localparam logic [3:0] OP_IDIV = 4'hA;
  localparam logic [3:0] OP_CLFL = 4'hB;

  localparam logic [2:0] REPL_NOT = 3'd0;
  localparam logic [2:0] REPL_NEG = 3'd1;
  localparam logic [2:0] REPL_INC = 3'd2;
  localparam logic [2:0] REPL_DEC = 3'd3;
  localparam logic [2:0] REPL_SHR = 3'd4;
  localparam logic [2:0] REPL_SHL = 3'd5;
  localparam logic [2:0] REPL_ROR = 3'd6;
  localparam logic [2:0] REPL_ROL = 3'd7;

  localparam logic [2:0] BINA_ADD  = 3'd0;
  localparam logic [2:0] BINA_AND  = 3'd1;
  localparam logic [2:0] BINA_OR   = 3'd2;
  localparam logic [2:0] BINA_XOR  = 3'd3;
  localparam logic [2:0] BINA_ADDC = 3'd4;
  localparam logic [2:0] BINA_MULL = 3'd5;
  localparam logic [2:0] BINA_MULH = 3'd6;
  localparam logic [2:0] BINA_SUB  = 3'd7;

  localparam logic [2:0] PUSF_TOP    = 3'd0;
  localparam logic [2:0] PUSF_SECOND = 3'd1;
  localparam logic [2:0] PUSF_FLAGS  = 3'd2;
  localparam logic [2:0] PUSF_DEPTH  = 3'd3;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SUBOP = 3'd2,
    ST_EXEC  = 3'd3,
    ST_EXEC2 = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    SM_IDLE  = 3'd0,
    SM_PUSH  = 3'd1,
    SM_POP   = 3'd2,
    SM_SWAP  = 3'd3,
    SM_ROLL  = 3'd4,  // replace top
    SM_ROLL2 = 3'd5,  // drop two, push one
    SM_RESET = 3'd6
  } stack_mode_e;

  // Minimum stack depth an opcode needs before it may touch the stack.
  function automatic logic [1:0] req_depth(input logic [3:0] op, input logic [2:0] sub);
    logic [1:0] r;
    r = 2'd0;
    case (op)
      OP_POP, OP_OUT, OP_DUP, OP_REPL:     r = 2'd1;
      OP_SWAP, OP_BINA, OP_MULT, OP_IDIV:  r = 2'd2;
      OP_PUSF: begin
        if (sub == PUSF_TOP)         r = 2'd1;
        else if (sub == PUSF_SECOND) r = 2'd2;
      end
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stack_calc_core_stack_array.sv
// Shift-style register stack: entry 0 is the top, vacated entries are zeroed,
// depth saturates at 0 and DEPTH.
module stack_array
  import stack_calc_core_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);

  logic [WIDTH-1:0] ent_q   [DEPTH];
  logic [WIDTH-1:0] ent_d   [DEPTH];
  logic [WIDTH-1:0] above_w [DEPTH];
  logic [WIDTH-1:0] below_w [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;

  // Neighbour taps for shifting: below feeds a push, above feeds a pop.
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_nb
    if (gi == 0) begin : g_first
      assign below_w[gi] = wdata;
    end else begin : g_rest
      assign below_w[gi] = ent_q[gi-1];
    end
    if (gi == DEPTH - 1) begin : g_last
      assign above_w[gi] = '0;
    end else begin : g_mid
      assign above_w[gi] = ent_q[gi+1];
    end
  end

  assign full  = (depth_q == DEPTH_C);
  assign empty = (depth_q == '0);

  always_comb begin
    depth_d = depth_q;
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    case (mode)
      SM_PUSH: begin
        for (int i = 0; i < DEPTH; i++) ent_d[i] = below_w[i];
        if (!full) depth_d = depth_q + DW'(1);
      end
      SM_POP: begin
        for (int i = 0; i < DEPTH; i++) ent_d[i] = above_w[i];
        if (!empty) depth_d = depth_q - DW'(1);
      end
      SM_SWAP: begin
        ent_d[0] = ent_q[1];
        ent_d[1] = ent_q[0];
      end
      SM_ROLL: ent_d[0] = wdata;
      SM_ROLL2: begin
        ent_d[0] = wdata;
        for (int i = 1; i < DEPTH; i++) ent_d[i] = above_w[i];
        if (!empty) depth_d = depth_q - DW'(1);
      end
      SM_RESET: begin
        for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
        depth_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      depth_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      depth_q <= depth_d;
    end
  end

  assign top    = (depth_q != '0)      ? ent_q[0] : '0;
  assign second = (depth_q >= DW'(2))  ? ent_q[1] : '0;
  assign depth  = depth_q;

endmodule

// File: rtl/stack_calc_core.sv
// Stack calculator core: beat-wise opcode/operand fetch over valid/ready,
// inline ALU, sticky status flags and a second EXEC cycle for two-word results.
module stack_calc_core
  import stack_calc_core_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int IN_BITS = 4,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IN_BITS-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [WIDTH-1:0]   top_word,
  output logic [WIDTH-1:0]   second_word,
  output logic [DW-1:0]      depth,
  output logic               carry_flag,
  output logic               error_flag,
  output logic               overflow_flag,
  output logic               underflow_flag,
  output logic               busy
);

  localparam int BEATS = WIDTH / IN_BITS;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e           state_q, state_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [2:0]       subop_q, subop_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d, error_q, error_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;

  stack_mode_e      sm_mode;
  logic [WIDTH-1:0] sm_wdata;
  logic [WIDTH-1:0] a_w, b_w;
  logic [DW-1:0]    depth_w;
  logic             full_w, empty_w;

  stack_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (sm_mode),
    .wdata  (sm_wdata),
    .top    (a_w),
    .second (b_w),
    .depth  (depth_w),
    .full   (full_w),
    .empty  (empty_w)
  );

  // ALU datapath; a is the top entry, b the one below it.
  logic [1:0]         need_w;
  logic               under_w, cin_w, div_zero_w;
  logic [WIDTH:0]     sum_w, diff_w;
  logic [2*WIDTH-1:0] prod_w;
  logic [WIDTH-1:0]   quot_w, rem_w, repl_w, bina_w, pusf_w;

  assign need_w     = req_depth(opcode_q, subop_q);
  assign under_w    = (need_w == 2'd2) ? (depth_w < DW'(2)) :
                      (need_w == 2'd1) ? empty_w : 1'b0;
  assign cin_w      = (subop_q == BINA_ADDC) && carry_q;
  assign sum_w      = {1'b0, a_w} + {1'b0, b_w} + {{WIDTH{1'b0}}, cin_w};
  assign diff_w     = {1'b0, b_w} - {1'b0, a_w};
  assign prod_w     = {{WIDTH{1'b0}}, a_w} * {{WIDTH{1'b0}}, b_w};
  assign div_zero_w = (a_w == '0);
  assign quot_w     = div_zero_w ? '0 : b_w / a_w;
  assign rem_w      = div_zero_w ? '0 : b_w % a_w;

  always_comb begin
    repl_w = ~a_w;
    case (subop_q)
      REPL_NOT: repl_w = ~a_w;
      REPL_NEG: repl_w = '0 - a_w;
      REPL_INC: repl_w = a_w + WIDTH'(1);
      REPL_DEC: repl_w = a_w - WIDTH'(1);
      REPL_SHR: repl_w = a_w >> 1;
      REPL_SHL: repl_w = a_w << 1;
      REPL_ROR: repl_w = {a_w[0], a_w[WIDTH-1:1]};
      REPL_ROL: repl_w = {a_w[WIDTH-2:0], a_w[WIDTH-1]};
      default:  repl_w = ~a_w;
    endcase
  end

  always_comb begin
    bina_w = sum_w[WIDTH-1:0];
    case (subop_q)
      BINA_ADD, BINA_ADDC: bina_w = sum_w[WIDTH-1:0];
      BINA_AND:  bina_w = a_w & b_w;
      BINA_OR:   bina_w = a_w | b_w;
      BINA_XOR:  bina_w = a_w ^ b_w;
      BINA_MULL: bina_w = prod_w[WIDTH-1:0];
      BINA_MULH: bina_w = prod_w[2*WIDTH-1:WIDTH];
      BINA_SUB:  bina_w = diff_w[WIDTH-1:0];
      default:   bina_w = sum_w[WIDTH-1:0];
    endcase
  end

  always_comb begin
    pusf_w = '0;
    case (subop_q)
      PUSF_TOP:    pusf_w = a_w;
      PUSF_SECOND: pusf_w = b_w;
      PUSF_FLAGS:  pusf_w = WIDTH'({ovf_q, unf_q, error_q, carry_q});
      PUSF_DEPTH:  pusf_w = WIDTH'(depth_w);
      default:     pusf_w = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    subop_d   = subop_q;
    operand_d = operand_q;
    beat_d    = beat_q;
    hi_d      = hi_q;
    out_d     = out_q;
    carry_d   = carry_q;
    error_d   = error_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    sm_mode   = SM_IDLE;
    sm_wdata  = '0;
    in_ready  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opcode_d = in_data[3:0];
          beat_d   = '0;
          if (in_data[3:0] == OP_PUSH)
            state_d = ST_LOAD;
          else if (in_data[3:0] == OP_PUSF || in_data[3:0] == OP_REPL ||
                   in_data[3:0] == OP_BINA)
            state_d = ST_SUBOP;
          else
            state_d = ST_EXEC;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          operand_d[int'(beat_q)*IN_BITS +: IN_BITS] = in_data;
          if (beat_q == BW'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = ST_EXEC;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      ST_SUBOP: begin
        in_ready = 1'b1;
        if (in_valid) begin
          subop_d = in_data[2:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (under_w) begin
          unf_d = 1'b1;
        end else begin
          case (opcode_q)
            OP_PUSH, OP_DUP, OP_PUSF: begin
              if (full_w) begin
                ovf_d = 1'b1;
              end else begin
                sm_mode  = SM_PUSH;
                sm_wdata = (opcode_q == OP_PUSH) ? operand_q :
                           (opcode_q == OP_DUP)  ? a_w : pusf_w;
              end
            end
            OP_POP:  sm_mode = SM_POP;
            OP_OUT:  out_d   = a_w;
            OP_SWAP: sm_mode = SM_SWAP;
            OP_REPL: begin
              sm_mode  = SM_ROLL;
              sm_wdata = repl_w;
            end
            OP_BINA: begin
              sm_mode  = SM_ROLL2;
              sm_wdata = bina_w;
              if (subop_q == BINA_ADD || subop_q == BINA_ADDC) carry_d = sum_w[WIDTH];
              else if (subop_q == BINA_SUB)                   carry_d = diff_w[WIDTH];
            end
            OP_MULT: begin
              sm_mode  = SM_ROLL2;
              sm_wdata = prod_w[WIDTH-1:0];
              hi_d     = prod_w[2*WIDTH-1:WIDTH];
              state_d  = ST_EXEC2;
            end
            OP_IDIV: begin
              sm_mode  = SM_ROLL2;
              sm_wdata = quot_w;
              hi_d     = rem_w;
              if (div_zero_w) error_d = 1'b1;
              state_d  = ST_EXEC2;
            end
            OP_CLFL: begin
              carry_d = 1'b0;
              error_d = 1'b0;
              ovf_d   = 1'b0;
              unf_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end
      // EXEC freed a slot, so this push always fits.
      ST_EXEC2: begin
        sm_mode  = SM_PUSH;
        sm_wdata = hi_q;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      opcode_q  <= '0;
      subop_q   <= '0;
      operand_q <= '0;
      beat_q    <= '0;
      hi_q      <= '0;
      out_q     <= '0;
      carry_q   <= 1'b0;
      error_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      subop_q   <= subop_d;
      operand_q <= operand_d;
      beat_q    <= beat_d;
      hi_q      <= hi_d;
      out_q     <= out_d;
      carry_q   <= carry_d;
      error_q   <= error_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign out_data       = out_q;
  assign top_word       = a_w;
  assign second_word    = b_w;
  assign depth          = depth_w;
  assign carry_flag     = carry_q;
  assign error_flag     = error_q;
  assign overflow_flag  = ovf_q;
  assign underflow_flag = unf_q;
  assign busy           = (state_q != ST_FETCH);

endmodule
